// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto VOICES nco+adsr pairs,
// scanning one voice per cycle and stealing the least-recently-used voice when full.
module voice_allocator #(
    parameter int unsigned VOICES    = 4,
    parameter int unsigned NOTE_BITS = 7,
    parameter int unsigned FREQ_BITS = 22
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          event_valid,
    output logic                          event_ready,
    input  logic                          event_on,
    input  logic [NOTE_BITS-1:0]          event_note,
    input  logic [FREQ_BITS-1:0]          event_freq,
    input  logic [VOICES-1:0]             voice_active,
    output logic [VOICES-1:0]             voice_gate,
    output logic [VOICES*FREQ_BITS-1:0]   voice_freq,
    output logic                          stolen
);

    localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RETRIG} state_e;

    state_e               state_q, state_d;
    logic                 on_q, on_d;
    logic [NOTE_BITS-1:0] ev_note_q, ev_note_d;
    logic [FREQ_BITS-1:0] ev_freq_q, ev_freq_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     tgt_q, tgt_d;

    logic                 match_vld_q, match_vld_d, free_vld_q, free_vld_d;
    logic                 rel_vld_q, rel_vld_d, old_vld_q, old_vld_d;
    logic [IDX_W-1:0]     match_idx_q, match_idx_d, free_idx_q, free_idx_d;
    logic [IDX_W-1:0]     rel_idx_q, rel_idx_d, old_idx_q, old_idx_d;
    logic [IDX_W-1:0]     rel_rank_q, rel_rank_d, old_rank_q, old_rank_d;

    logic [NOTE_BITS-1:0] note_q [VOICES];
    logic [NOTE_BITS-1:0] note_d [VOICES];
    logic [FREQ_BITS-1:0] freq_q [VOICES];
    logic [FREQ_BITS-1:0] freq_d [VOICES];
    logic [IDX_W-1:0]     rank_q [VOICES];
    logic [IDX_W-1:0]     rank_d [VOICES];
    logic [VOICES-1:0]    gate_q, gate_d;
    logic                 stolen_q, stolen_d;

    logic                 scan_gate, scan_active;
    logic [IDX_W-1:0]     scan_rank;
    logic [IDX_W-1:0]     tgt_c;
    logic                 steal_c;

    assign scan_gate   = gate_q[idx_q];
    assign scan_active = voice_active[idx_q];
    assign scan_rank   = rank_q[idx_q];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (event_valid) state_d = SCAN;
            SCAN:    if (idx_q == IDX_W'(VOICES - 1)) state_d = COMMIT;
            COMMIT:  state_d = on_q ? RETRIG : IDLE;
            RETRIG:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Note-on target priority: match, free, releasing, oldest gated
    always_comb begin
        tgt_c   = old_idx_q;
        steal_c = 1'b1;
        if (match_vld_q) begin
            tgt_c   = match_idx_q;
            steal_c = 1'b0;
        end else if (free_vld_q) begin
            tgt_c   = free_idx_q;
            steal_c = 1'b0;
        end else if (rel_vld_q) begin
            tgt_c   = rel_idx_q;
            steal_c = 1'b0;
        end
    end

    // Datapath / output next values
    always_comb begin
        on_d        = on_q;
        ev_note_d   = ev_note_q;
        ev_freq_d   = ev_freq_q;
        idx_d       = idx_q;
        tgt_d       = tgt_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        rel_vld_d   = rel_vld_q;
        rel_idx_d   = rel_idx_q;
        rel_rank_d  = rel_rank_q;
        old_vld_d   = old_vld_q;
        old_idx_d   = old_idx_q;
        old_rank_d  = old_rank_q;
        note_d      = note_q;
        freq_d      = freq_q;
        rank_d      = rank_q;
        gate_d      = gate_q;
        stolen_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (event_valid) begin
                    on_d        = event_on;
                    ev_note_d   = event_note;
                    ev_freq_d   = event_freq;
                    idx_d       = '0;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    rel_vld_d   = 1'b0;
                    old_vld_d   = 1'b0;
                end
            end
            SCAN: begin
                idx_d = IDX_W'(idx_q + 1'b1);
                if (scan_gate && note_q[idx_q] == ev_note_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!scan_gate && !scan_active && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                if (!scan_gate && scan_active && (!rel_vld_q || scan_rank < rel_rank_q)) begin
                    rel_vld_d  = 1'b1;
                    rel_idx_d  = idx_q;
                    rel_rank_d = scan_rank;
                end
                if (scan_gate && (!old_vld_q || scan_rank < old_rank_q)) begin
                    old_vld_d  = 1'b1;
                    old_idx_d  = idx_q;
                    old_rank_d = scan_rank;
                end
            end
            COMMIT: begin
                if (on_q) begin
                    tgt_d         = tgt_c;
                    freq_d[tgt_c] = ev_freq_q;
                    note_d[tgt_c] = ev_note_q;
                    gate_d[tgt_c] = 1'b0;
                    stolen_d      = steal_c;
                    for (int unsigned j = 0; j < VOICES; j++) begin
                        if (IDX_W'(j) == tgt_c)
                            rank_d[j] = IDX_W'(VOICES - 1);
                        else if (rank_q[j] > rank_q[tgt_c])
                            rank_d[j] = rank_q[j] - 1'b1;
                    end
                end else if (match_vld_q) begin
                    gate_d[match_idx_q] = 1'b0;
                end
            end
            RETRIG: gate_d[tgt_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            on_q        <= 1'b0;
            ev_note_q   <= '0;
            ev_freq_q   <= '0;
            idx_q       <= '0;
            tgt_q       <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            rel_vld_q   <= 1'b0;
            rel_idx_q   <= '0;
            rel_rank_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_rank_q  <= '0;
            gate_q      <= '0;
            stolen_q    <= 1'b0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                freq_q[i] <= '0;
                rank_q[i] <= IDX_W'(i);
            end
        end else begin
            on_q        <= on_d;
            ev_note_q   <= ev_note_d;
            ev_freq_q   <= ev_freq_d;
            idx_q       <= idx_d;
            tgt_q       <= tgt_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            rel_vld_q   <= rel_vld_d;
            rel_idx_q   <= rel_idx_d;
            rel_rank_q  <= rel_rank_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_rank_q  <= old_rank_d;
            gate_q      <= gate_d;
            stolen_q    <= stolen_d;
            note_q      <= note_d;
            freq_q      <= freq_d;
            rank_q      <= rank_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < VOICES; i++)
            voice_freq[i*FREQ_BITS +: FREQ_BITS] = freq_q[i];
    end

    assign voice_gate  = gate_q;
    assign stolen      = stolen_q;
    assign event_ready = (state_q == IDLE) && !reset;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, steal, release reuse, drop,
// retrigger and mid-event reset, checked cycle by cycle against a hand-built model.
module tb_voice_allocator;

    localparam int unsigned V  = 4;
    localparam int unsigned NB = 7;
    localparam int unsigned FB = 22;

    logic              clock = 1'b0;
    logic              reset;
    logic              event_valid;
    logic              event_ready;
    logic              event_on;
    logic [NB-1:0]     event_note;
    logic [FB-1:0]     event_freq;
    logic [V-1:0]      voice_active;
    logic [V-1:0]      voice_gate;
    logic [V*FB-1:0]   voice_freq;
    logic              stolen;

    int vectors     = 0;
    int miscompares = 0;

    logic [V-1:0]  eg;
    logic [FB-1:0] ef [V];

    voice_allocator #(.VOICES(V), .NOTE_BITS(NB), .FREQ_BITS(FB)) dut (
        .clock        (clock),
        .reset        (reset),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_on     (event_on),
        .event_note   (event_note),
        .event_freq   (event_freq),
        .voice_active (voice_active),
        .voice_gate   (voice_gate),
        .voice_freq   (voice_freq),
        .stolen       (stolen)
    );

    always #5 clock = ~clock;

    function automatic logic [V*FB-1:0] flat_freq();
        logic [V*FB-1:0] f;
        for (int i = 0; i < V; i++) f[i*FB +: FB] = ef[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_ready, input logic exp_stolen);
        chk({tag, " gate"},   128'(voice_gate), 128'(eg));
        chk({tag, " freq"},   128'(voice_freq), 128'(flat_freq()));
        chk({tag, " ready"},  128'(event_ready), 128'(exp_ready));
        chk({tag, " stolen"}, 128'(stolen), 128'(exp_stolen));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!event_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ready_wait", 128'(event_ready), 128'(1'b1));
    endtask

    // Present one event; returns 1 time unit after the accept edge
    task automatic send(input logic on, input logic [NB-1:0] note, input logic [FB-1:0] freq);
        wait_ready();
        event_valid = 1'b1;
        event_on    = on;
        event_note  = note;
        event_freq  = freq;
        @(posedge clock); #1;
        event_valid = 1'b0;
        event_on    = 1'($urandom);
        event_note  = NB'($urandom);
        event_freq  = FB'($urandom);
    endtask

    task automatic note_on(input logic [NB-1:0] note, input logic [FB-1:0] freq,
                           input int v, input logic steal);
        send(1'b1, note, freq);
        check_all("on_accept", 1'b0, 1'b0);
        for (int k = 1; k <= V; k++) begin
            @(posedge clock); #1;
            check_all("on_scan", 1'b0, 1'b0);
        end
        @(posedge clock); #1;
        eg[v] = 1'b0;
        ef[v] = freq;
        check_all("on_commit", 1'b0, steal);
        @(posedge clock); #1;
        eg[v] = 1'b1;
        check_all("on_retrig", 1'b1, 1'b0);
    endtask

    task automatic note_off(input logic [NB-1:0] note, input int v);
        send(1'b0, note, FB'(0));
        for (int k = 1; k <= V; k++) begin
            @(posedge clock); #1;
            check_all("off_scan", 1'b0, 1'b0);
        end
        @(posedge clock); #1;
        if (v >= 0) eg[v] = 1'b0;
        check_all("off_commit", 1'b1, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        event_valid  = 1'b0;
        event_on     = 1'b0;
        event_note   = '0;
        event_freq   = '0;
        voice_active = '0;
        eg           = '0;
        for (int i = 0; i < V; i++) ef[i] = '0;

        repeat (2) @(posedge clock);
        #1;
        check_all("rst_hold", 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_all("rst_state", 1'b1, 1'b0);

        // Fill all voices in order from free slots
        note_on(7'd60, 22'd440, 0, 1'b0);
        note_on(7'd64, 22'd554, 1, 1'b0);
        note_on(7'd67, 22'd659, 2, 1'b0);
        note_on(7'd72, 22'd880, 3, 1'b0);

        // All gated: steal oldest (voice 0)
        note_on(7'd76, 22'd1047, 0, 1'b1);

        // Release voice 1 while its envelope is still active, then reuse it
        voice_active = '1;
        note_off(7'd64, 1);
        note_on(7'd79, 22'd1568, 1, 1'b0);

        // Unheld note-off is dropped
        note_off(7'd99, -1);

        // Retrigger a held note with a new frequency
        note_on(7'd67, 22'd700, 2, 1'b0);

        // Reset in the middle of a scan
        voice_active = '0;
        send(1'b1, 7'd50, 22'd123);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        eg = '0;
        for (int i = 0; i < V; i++) ef[i] = '0;
        check_all("rst_mid", 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_all("rst_release", 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            check_all("rst_quiet", 1'b1, 1'b0);
        end

        // Fresh allocation after reset lands on voice 0
        note_on(7'd62, 22'd494, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
